// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the shared register-file bus.
// Each master owns a 1-deep command slot; accesses run IDLE->ISSUE->WAIT->ACK.
module reg_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_busy,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ovf,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_busy,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ovf,
  input  logic              ovf_clr,
  output logic              reg_read,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        w_req;
  logic [1:0]        w_we;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_wdata [2];

  logic [1:0]        r_pend;
  logic [1:0]        r_we;
  logic [ADDR_W-1:0] r_addr  [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [DATA_W-1:0] r_rdata [2];
  logic [1:0]        r_ovf;

  logic              r_owner;
  logic              r_last;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [DATA_W-1:0] r_reg_wdata;

  logic              w_sel;
  logic              w_grant;
  logic [1:0]        w_clr;

  assign w_req      = {m1_req, m0_req};
  assign w_we       = {m1_we, m0_we};
  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_wdata[0] = m0_wdata;
  assign w_wdata[1] = m1_wdata;

  // Ties go to whichever master was not served last.
  always_comb begin
    w_sel = 1'b0;
    unique case (1'b1)
      (&r_pend):              w_sel = ~r_last;
      (r_pend == 2'b10):      w_sel = 1'b1;
      default:                w_sel = 1'b0;
    endcase
  end

  assign w_grant = (r_state == S_IDLE) && (|r_pend);

  // The served slot frees on entry to ACK so a new command fits in ACK.
  always_comb begin
    w_clr = 2'b00;
    if (r_state == S_WAIT) begin
      w_clr = r_owner ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 2'b00;
      r_we   <= 2'b00;
      r_ovf  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_req[i] && !r_pend[i]) begin
          r_pend[i]  <= 1'b1;
          r_we[i]    <= w_we[i];
          r_addr[i]  <= w_addr[i];
          r_wdata[i] <= w_wdata[i];
        end else if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (w_req[i] && r_pend[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (ovf_clr) begin
          r_ovf[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else if (w_grant) begin
      r_owner     <= w_sel;
      r_last      <= w_sel;
      r_reg_addr  <= r_addr[w_sel];
      r_reg_wdata <= r_wdata[w_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else if (r_state == S_WAIT && !r_we[r_owner]) begin
      r_rdata[r_owner] <= reg_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    reg_read  = 1'b0;
    reg_write = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    unique case (r_state)
      S_ISSUE: begin
        reg_read  = ~r_we[r_owner];
        reg_write = r_we[r_owner];
      end
      S_ACK: begin
        m0_ack = ~r_owner;
        m1_ack = r_owner;
      end
      default: ;
    endcase
  end

  assign m0_busy   = r_pend[0];
  assign m1_busy   = r_pend[1];
  assign m0_ovf    = r_ovf[0];
  assign m1_ovf    = r_ovf[1];
  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a simple register-file model.
// Reads return 0x3C at 0x10, otherwise addr ^ 0x5A.
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we, ovf_clr;
  logic [5:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_busy, m0_ack, m0_ovf;
  logic       m1_busy, m1_ack, m1_ovf;
  logic [7:0] m0_rdata, m1_rdata;
  logic       reg_read, reg_write;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int n_pass = 0;
  int n_chk  = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int w0, r0;

  always #5 clk = ~clk;

  reg_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_busy(m0_busy), .m0_ack(m0_ack),
    .m0_rdata(m0_rdata), .m0_ovf(m0_ovf),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_busy(m1_busy), .m1_ack(m1_ack),
    .m1_rdata(m1_rdata), .m1_ovf(m1_ovf),
    .ovf_clr(ovf_clr),
    .reg_read(reg_read), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always @(posedge clk) begin
    if (reg_read) begin
      reg_rdata <= (reg_addr == 6'h10) ? 8'h3C : ({2'b00, reg_addr} ^ 8'h5A);
      rd_cnt <= rd_cnt + 1;
    end else begin
      reg_rdata <= 8'h00;
    end
    if (reg_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; ovf_clr = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (3) tick();
    chk("rst_strobes", {reg_read, reg_write}, 0);
    chk("rst_busy", {m0_busy, m1_busy}, 0);
    chk("rst_ack", {m0_ack, m1_ack}, 0);
    chk("rst_ovf", {m0_ovf, m1_ovf}, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // 1: M0 write
    m0_req = 1; m0_we = 1; m0_addr = 6'h05; m0_wdata = 8'hA5;
    tick(); m0_req = 0;
    chk("t1_busy", m0_busy, 1);
    chk("t1_nowr_T1", reg_write, 0);
    tick();
    chk("t1_wr", {reg_write, reg_read}, 2'b10);
    chk("t1_addr", reg_addr, 6'h05);
    chk("t1_wdata", reg_wdata, 8'hA5);
    tick();
    chk("t1_noack_T3", m0_ack, 0);
    tick();
    chk("t1_ack", m0_ack, 1);
    chk("t1_busy_lo", m0_busy, 0);
    tick();
    chk("t1_ack_pulse", m0_ack, 0);

    // 2: M1 read
    m1_req = 1; m1_we = 0; m1_addr = 6'h10;
    tick(); m1_req = 0;
    tick();
    chk("t2_rd", {reg_read, reg_write}, 2'b10);
    chk("t2_addr", reg_addr, 6'h10);
    tick(); tick();
    chk("t2_ack", {m1_ack, m0_ack}, 2'b10);
    chk("t2_rdata", m1_rdata, 8'h3C);
    chk("t2_m0_rdata", m0_rdata, 8'h00);
    tick();

    // 3: contention after reset, M0 first
    rst_n = 0; tick(); rst_n = 1; tick();
    m0_req = 1; m0_we = 0; m0_addr = 6'h05;
    m1_req = 1; m1_we = 1; m1_addr = 6'h20; m1_wdata = 8'h77;
    tick(); m0_req = 0; m1_req = 0;
    chk("t3_busy", {m0_busy, m1_busy}, 2'b11);
    tick();
    chk("t3_m0_rd", reg_read, 1);
    chk("t3_m0_addr", reg_addr, 6'h05);
    tick(); tick();
    chk("t3_m0_ack", {m0_ack, m1_ack}, 2'b10);
    chk("t3_m0_rdata", m0_rdata, 8'h5F);
    chk("t3_m1_wait", m1_busy, 1);
    tick();
    chk("t3_gap", reg_write, 0);
    tick();
    chk("t3_m1_wr", reg_write, 1);
    chk("t3_m1_addr", reg_addr, 6'h20);
    chk("t3_m1_wdata", reg_wdata, 8'h77);
    tick(); tick();
    chk("t3_m1_ack", {m0_ack, m1_ack}, 2'b01);
    chk("t3_m0_keep", m0_rdata, 8'h5F);
    tick();
    // make M0 the last winner, then contend again: M1 first
    m0_req = 1; m0_we = 1; m0_addr = 6'h06; m0_wdata = 8'h11;
    tick(); m0_req = 0;
    repeat (3) tick();
    chk("t3_solo_ack", m0_ack, 1);
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 6'h07; m0_wdata = 8'h12;
    m1_req = 1; m1_we = 0; m1_addr = 6'h11;
    tick(); m0_req = 0; m1_req = 0;
    tick();
    chk("t3_rr_rd", reg_read, 1);
    chk("t3_rr_addr", reg_addr, 6'h11);
    tick(); tick();
    chk("t3_rr_ack", {m0_ack, m1_ack}, 2'b01);
    chk("t3_rr_rdata", m1_rdata, 8'h4B);
    tick(); tick();
    chk("t3_rr_wr", reg_write, 1);
    chk("t3_rr_waddr", reg_addr, 6'h07);
    tick(); tick();
    chk("t3_rr_ack2", {m0_ack, m1_ack}, 2'b10);
    chk("t3_m1_keep", m1_rdata, 8'h4B);
    tick();

    // 4: overflow while busy; same-edge clear loses
    w0 = wr_cnt;
    m0_req = 1; m0_we = 1; m0_addr = 6'h08; m0_wdata = 8'h22;
    tick();
    chk("t4_ovf_pre", m0_ovf, 0);
    m0_addr = 6'h09; m0_wdata = 8'h33; ovf_clr = 1;
    tick(); m0_req = 0; ovf_clr = 0;
    chk("t4_ovf_set", m0_ovf, 1);
    chk("t4_wr", reg_write, 1);
    chk("t4_addr", reg_addr, 6'h08);
    chk("t4_wdata", reg_wdata, 8'h22);
    tick(); tick();
    chk("t4_ack", m0_ack, 1);
    tick(); tick();
    chk("t4_one_access", wr_cnt, w0 + 1);
    chk("t4_ovf_sticky", m0_ovf, 1);
    chk("t4_idle", m0_busy, 0);
    ovf_clr = 1;
    tick(); ovf_clr = 0;
    chk("t4_ovf_clr", m0_ovf, 0);

    // 5: reset during ISSUE
    m1_req = 1; m1_we = 0; m1_addr = 6'h12;
    m0_req = 1; m0_we = 1; m0_addr = 6'h0A; m0_wdata = 8'h44;
    tick(); m0_req = 0; m1_req = 0;
    tick();
    chk("t5_issue", {reg_read, reg_addr}, {1'b1, 6'h12});
    rst_n = 0;
    #2;
    chk("t5_abort", {reg_read, reg_write}, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("t5_busy", {m0_busy, m1_busy}, 0);
    w0 = wr_cnt; r0 = rd_cnt;
    repeat (5) begin
      chk("t5_noack", {m0_ack, m1_ack}, 0);
      tick();
    end
    chk("t5_no_strobe", {wr_cnt, rd_cnt}, {w0, r0});

    // 6: back-to-back request in ACK
    m0_req = 1; m0_we = 0; m0_addr = 6'h10;
    tick(); m0_req = 0;
    repeat (3) tick();
    chk("t6_ack1", m0_ack, 1);
    chk("t6_rdata", m0_rdata, 8'h3C);
    m0_req = 1; m0_we = 1; m0_addr = 6'h09; m0_wdata = 8'h5A;
    tick(); m0_req = 0;
    chk("t6_accept", {m0_busy, m0_ack}, 2'b10);
    tick();
    chk("t6_wr", reg_write, 1);
    chk("t6_addr", {reg_addr, reg_wdata}, {6'h09, 8'h5A});
    tick();
    chk("t6_nodup", m0_ack, 0);
    tick();
    chk("t6_ack2", m0_ack, 1);
    chk("t6_rdata_keep", m0_rdata, 8'h3C);
    tick();
    chk("t6_ack_end", m0_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
